// File: rtl/uart_serial_engine.sv
// Full-duplex UART engine: 5-8 data bits, none/even/odd parity, 1/2 stop bits,
// valid/ready TX handshake, held RX output with framing/parity/overrun flags.
module uart_serial_engine #(
  parameter int DIV_W = 16,
  parameter int OVS   = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [DIV_W-1:0] Div,
  input  logic [3:0]       NBits,
  input  logic [1:0]       Parity,
  input  logic             Stop2,
  input  logic [7:0]       TxData,
  input  logic             TxValid,
  output logic             TxReady,
  output logic             Tx,
  input  logic             Rx,
  output logic [7:0]       RxData,
  output logic             RxValid,
  input  logic             RxReady,
  output logic             RxFrameErr,
  output logic             RxParityErr,
  output logic             RxOverrun
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_WAIT  = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_DATA  = 3'd3;
  localparam logic [2:0] TX_PAR   = 3'd4;
  localparam logic [2:0] TX_STOP  = 3'd5;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_PAR   = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;
  localparam logic [2:0] RX_BREAK = 3'd5;

  function automatic logic [3:0] effBits(input logic [3:0] n);
    effBits = (n >= 4'd5 && n <= 4'd8) ? n : 4'd8;
  endfunction

  logic [DIV_W-1:0] tickCnt;
  logic             tick;

  logic [3:0] cfgNb;
  logic [7:0] cfgMask;
  logic       cfgParEn;
  logic       cfgParOdd;

  assign cfgNb     = effBits(NBits);
  assign cfgMask   = 8'hFF >> (4'd8 - cfgNb);
  assign cfgParEn  = (Parity == 2'b01) || (Parity == 2'b10);
  assign cfgParOdd = (Parity == 2'b10);

  // >= rather than == so lowering Div on the fly never overshoots
  assign tick = (tickCnt >= Div);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tickCnt <= '0;
    end else if (tick) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tickCnt + 1'b1;
    end
  end

  logic [2:0]    txState;
  logic          txLine;
  logic [7:0]    txShift;
  logic [CW-1:0] txCnt;
  logic [2:0]    txIdx;
  logic [3:0]    txNb;
  logic          txParEn;
  logic          txParBit;
  logic          txStop2;
  logic          txStop2nd;

  assign Tx      = txLine;
  assign TxReady = (txState == TX_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      txState   <= TX_IDLE;
      txLine    <= 1'b1;
      txShift   <= '0;
      txCnt     <= '0;
      txIdx     <= '0;
      txNb      <= 4'd8;
      txParEn   <= 1'b0;
      txParBit  <= 1'b0;
      txStop2   <= 1'b0;
      txStop2nd <= 1'b0;
    end else begin
      unique case (txState)
        TX_IDLE: begin
          if (TxValid) begin
            txShift  <= TxData & cfgMask;
            txNb     <= cfgNb;
            txParEn  <= cfgParEn;
            txParBit <= (^(TxData & cfgMask)) ^ cfgParOdd;
            txStop2  <= Stop2;
            txState  <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tick) begin
            txLine  <= 1'b0;
            txCnt   <= '0;
            txState <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            if (txCnt == BIT_LAST) begin
              txCnt   <= '0;
              txIdx   <= '0;
              txLine  <= txShift[0];
              txState <= TX_DATA;
            end else begin
              txCnt <= txCnt + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (txCnt == BIT_LAST) begin
              txCnt <= '0;
              if ({1'b0, txIdx} == txNb - 4'd1) begin
                if (txParEn) begin
                  txLine  <= txParBit;
                  txState <= TX_PAR;
                end else begin
                  txLine    <= 1'b1;
                  txStop2nd <= 1'b0;
                  txState   <= TX_STOP;
                end
              end else begin
                txIdx   <= txIdx + 1'b1;
                txLine  <= txShift[1];
                txShift <= txShift >> 1;
              end
            end else begin
              txCnt <= txCnt + 1'b1;
            end
          end
        end
        TX_PAR: begin
          if (tick) begin
            if (txCnt == BIT_LAST) begin
              txCnt     <= '0;
              txLine    <= 1'b1;
              txStop2nd <= 1'b0;
              txState   <= TX_STOP;
            end else begin
              txCnt <= txCnt + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (txCnt == BIT_LAST) begin
              txCnt <= '0;
              if (txStop2 && !txStop2nd) begin
                txStop2nd <= 1'b1;
              end else begin
                txState <= TX_IDLE;
              end
            end else begin
              txCnt <= txCnt + 1'b1;
            end
          end
        end
        default: begin
          txState <= TX_IDLE;
          txLine  <= 1'b1;
        end
      endcase
    end
  end

  logic          rxS1;
  logic          rxS2;
  logic [2:0]    rxState;
  logic [7:0]    rxShift;
  logic [CW-1:0] rxCnt;
  logic [2:0]    rxIdx;
  logic [3:0]    rxNb;
  logic          rxParEn;
  logic          rxParOdd;
  logic          rxParBit;
  logic [7:0]    rxDataR;
  logic          rxValidR;
  logic          rxFrameR;
  logic          rxParR;
  logic          rxOvR;

  assign RxData      = rxDataR;
  assign RxValid     = rxValidR;
  assign RxFrameErr  = rxFrameR;
  assign RxParityErr = rxParR;
  assign RxOverrun   = rxOvR;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rxS1 <= 1'b1;
      rxS2 <= 1'b1;
    end else begin
      rxS1 <= Rx;
      rxS2 <= rxS1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rxState  <= RX_IDLE;
      rxShift  <= '0;
      rxCnt    <= '0;
      rxIdx    <= '0;
      rxNb     <= 4'd8;
      rxParEn  <= 1'b0;
      rxParOdd <= 1'b0;
      rxParBit <= 1'b0;
      rxDataR  <= '0;
      rxValidR <= 1'b0;
      rxFrameR <= 1'b0;
      rxParR   <= 1'b0;
      rxOvR    <= 1'b0;
    end else begin
      rxOvR <= 1'b0;
      if (rxValidR && RxReady) begin
        rxValidR <= 1'b0;
      end
      unique case (rxState)
        RX_IDLE: begin
          if (tick && !rxS2) begin
            rxCnt    <= '0;
            rxNb     <= cfgNb;
            rxParEn  <= cfgParEn;
            rxParOdd <= cfgParOdd;
            rxState  <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rxCnt == HALF_LAST) begin
              rxCnt   <= '0;
              rxIdx   <= '0;
              rxShift <= '0;
              rxState <= rxS2 ? RX_IDLE : RX_DATA;
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rxCnt == BIT_LAST) begin
              rxCnt          <= '0;
              rxShift[rxIdx] <= rxS2;
              if ({1'b0, rxIdx} == rxNb - 4'd1) begin
                rxState <= rxParEn ? RX_PAR : RX_STOP;
              end else begin
                rxIdx <= rxIdx + 1'b1;
              end
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
        end
        RX_PAR: begin
          if (tick) begin
            if (rxCnt == BIT_LAST) begin
              rxCnt    <= '0;
              rxParBit <= rxS2;
              rxState  <= RX_STOP;
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rxCnt == BIT_LAST) begin
              rxCnt <= '0;
              // a same-cycle acknowledge frees the holding register
              if (rxValidR && !RxReady) begin
                rxOvR <= 1'b1;
              end else begin
                rxDataR  <= rxShift;
                rxValidR <= 1'b1;
                rxFrameR <= !rxS2;
                rxParR   <= rxParEn &&
                            (rxParBit != ((^rxShift) ^ rxParOdd));
              end
              rxState <= rxS2 ? RX_IDLE : RX_BREAK;
            end else begin
              rxCnt <= rxCnt + 1'b1;
            end
          end
        end
        RX_BREAK: begin
          if (rxS2) begin
            rxState <= RX_IDLE;
          end
        end
        default: begin
          rxState <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_serial_engine.sv
// Directed bench for uart_serial_engine: reset, loopback framing,
// parity/framing errors, glitch rejection and overrun.
module tb_uart_serial_engine;

  logic        Clk;
  logic        Rst_n;
  logic [15:0] Div;
  logic [3:0]  NBits;
  logic [1:0]  Parity;
  logic        Stop2;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;
  logic        Tx;
  logic        rxIn;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        RxFrameErr;
  logic        RxParityErr;
  logic        RxOverrun;

  logic loop;
  logic rxDrv;
  int   testCnt;
  int   failCnt;
  int   ovCnt;

  assign rxIn = loop ? Tx : rxDrv;

  uart_serial_engine #(.DIV_W(16), .OVS(16)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Div(Div),
    .NBits(NBits),
    .Parity(Parity),
    .Stop2(Stop2),
    .TxData(TxData),
    .TxValid(TxValid),
    .TxReady(TxReady),
    .Tx(Tx),
    .Rx(rxIn),
    .RxData(RxData),
    .RxValid(RxValid),
    .RxReady(RxReady),
    .RxFrameErr(RxFrameErr),
    .RxParityErr(RxParityErr),
    .RxOverrun(RxOverrun)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    if (RxOverrun) ovCnt <= ovCnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    TxData  = d;
    TxValid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (TxReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    @(posedge Clk);
    @(negedge Clk);
    TxValid = 1'b0;
    check("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic txMonitor(output int cnt, output logic [15:0] bits);
    int k;
    cnt  = 0;
    bits = '0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge Clk);
      if (TxReady) break;
      cnt++;
      if (n >= 9 && ((n - 9) % 16) == 0) begin
        k = (n - 9) / 16;
        if (k < 16) bits[k] = Tx;
      end
    end
  endtask

  task automatic waitRx(input string tag, input int maxCyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      if (RxValid) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic ackRx();
    RxReady = 1'b1;
    @(negedge Clk);
    RxReady = 1'b0;
  endtask

  task automatic driveFrame(input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      rxDrv = bits[k];
      repeat (16) @(negedge Clk);
    end
    rxDrv = 1'b1;
  endtask

  int          cnt;
  int          ovBefore;
  logic [15:0] bits;

  initial begin
    testCnt = 0;
    failCnt = 0;
    ovCnt   = 0;
    Rst_n   = 1'b0;
    Div     = 16'd0;
    NBits   = 4'd8;
    Parity  = 2'b00;
    Stop2   = 1'b0;
    TxData  = 8'h00;
    TxValid = 1'b0;
    RxReady = 1'b0;
    loop    = 1'b1;
    rxDrv   = 1'b1;

    @(negedge Clk);
    check("rst_tx", {31'd0, Tx}, 32'd1);
    check("rst_txready", {31'd0, TxReady}, 32'd1);
    check("rst_rxvalid", {31'd0, RxValid}, 32'd0);
    check("rst_rxdata", {24'd0, RxData}, 32'd0);
    check("rst_flags", {29'd0, RxFrameErr, RxParityErr, RxOverrun}, 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // 1: reset in the middle of a transmit
    sendByte(8'h5A);
    repeat (40) @(negedge Clk);
    check("t1_busy", {31'd0, TxReady}, 32'd0);
    #2 Rst_n = 1'b0;
    #1;
    check("t1_rst_tx", {31'd0, Tx}, 32'd1);
    check("t1_rst_ready", {31'd0, TxReady}, 32'd1);
    check("t1_rst_rxvalid", {31'd0, RxValid}, 32'd0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("t1_post_tx", {31'd0, Tx}, 32'd1);
    check("t1_post_ready", {31'd0, TxReady}, 32'd1);
    repeat (200) @(negedge Clk);
    check("t1_no_rx", {31'd0, RxValid}, 32'd0);

    // 2: 8N1 loopback, timing and back-to-back accept
    sendByte(8'hA5);
    TxData  = 8'h3C;
    TxValid = 1'b1;
    txMonitor(cnt, bits);
    check("t2_frame_ticks", cnt, 32'd160);
    check("t2_bits", {16'd0, bits}, 32'h0000_034A);
    check("t2_ready_high", {31'd0, TxReady}, 32'd1);
    @(negedge Clk);
    check("t2_b2b_accept", {31'd0, TxReady}, 32'd0);
    TxValid = 1'b0;
    check("t2_rxvalid", {31'd0, RxValid}, 32'd1);
    check("t2_rxdata", {24'd0, RxData}, 32'h0000_00A5);
    check("t2_flags", {30'd0, RxFrameErr, RxParityErr}, 32'd0);
    ackRx();
    check("t2_ack_clear", {31'd0, RxValid}, 32'd0);
    waitRx("t2_rx2_timeout", 400);
    check("t2_rxdata2", {24'd0, RxData}, 32'h0000_003C);
    ackRx();
    for (int i = 0; i < 400 && !TxReady; i++) @(negedge Clk);
    check("t2_no_overrun", ovCnt, 32'd0);

    // 3: 7 data bits, even parity, two stop bits
    NBits  = 4'd7;
    Parity = 2'b01;
    Stop2  = 1'b1;
    sendByte(8'h41);
    txMonitor(cnt, bits);
    check("t3_frame_ticks", cnt, 32'd176);
    check("t3_bits", {16'd0, bits}, 32'h0000_0682);
    waitRx("t3_rx_timeout", 100);
    check("t3_rxdata", {24'd0, RxData}, 32'h0000_0041);
    check("t3_flags", {30'd0, RxFrameErr, RxParityErr}, 32'd0);
    ackRx();

    // 4: externally driven 8O1 frame with a wrong parity bit
    loop   = 1'b0;
    NBits  = 4'd8;
    Parity = 2'b10;
    Stop2  = 1'b0;
    repeat (20) @(negedge Clk);
    driveFrame(16'h0478, 11);
    waitRx("t4_rx_timeout", 100);
    check("t4_rxdata", {24'd0, RxData}, 32'h0000_003C);
    check("t4_parerr", {31'd0, RxParityErr}, 32'd1);
    check("t4_frameerr", {31'd0, RxFrameErr}, 32'd0);
    ackRx();

    // 5: break condition, then a short glitch
    Parity = 2'b00;
    repeat (20) @(negedge Clk);
    rxDrv = 1'b0;
    repeat (170) @(negedge Clk);
    check("t5_rxvalid", {31'd0, RxValid}, 32'd1);
    check("t5_frameerr", {31'd0, RxFrameErr}, 32'd1);
    check("t5_rxdata", {24'd0, RxData}, 32'd0);
    ackRx();
    repeat (70) @(negedge Clk);
    check("t5_break_hold", {31'd0, RxValid}, 32'd0);
    rxDrv = 1'b1;
    repeat (40) @(negedge Clk);
    check("t5_after_break", {31'd0, RxValid}, 32'd0);
    rxDrv = 1'b0;
    repeat (4) @(negedge Clk);
    rxDrv = 1'b1;
    repeat (200) @(negedge Clk);
    check("t5_glitch", {31'd0, RxValid}, 32'd0);
    check("t5_no_overrun", ovCnt, 32'd0);

    // 6: overrun with RxReady held low
    driveFrame(16'h0222, 10);
    waitRx("t6_rx1_timeout", 100);
    check("t6_rxdata1", {24'd0, RxData}, 32'h0000_0011);
    ovBefore = ovCnt;
    driveFrame(16'h0244, 10);
    repeat (20) @(negedge Clk);
    check("t6_overrun", ovCnt - ovBefore, 32'd1);
    check("t6_rxdata_kept", {24'd0, RxData}, 32'h0000_0011);
    check("t6_rxvalid", {31'd0, RxValid}, 32'd1);
    ackRx();
    check("t6_ack_clear", {31'd0, RxValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
